// File: rtl/al_accel_cfg_pkg.sv
// Shared definitions for the layer-configuration front end: register map,
// CTRL/STATUS bit positions, FSM encoding and layer-type codes.
package al_accel_cfg_pkg;

  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_STATUS = 32'h04;
  localparam logic [31:0] OFF_K3D    = 32'h30;
  localparam logic [31:0] OFF_SIZE2D = 32'h34;

  // Word indices of the plain RW config words (byte offset = index * 4)
  localparam int W_IBASE  = 2;
  localparam int W_KWBASE = 3;
  localparam int W_OBASE  = 4;
  localparam int W_BBASE  = 5;
  localparam int W_PSBASE = 6;
  localparam int W_LAYER  = 7;
  localparam int W_KSIZE  = 8;
  localparam int W_DEPTH  = 9;
  localparam int W_IFM    = 10;
  localparam int W_OFM    = 11;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_DONE_CLR = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [3:0] LT_CONV   = 4'd0;
  localparam logic [3:0] LT_DWCONV = 4'd1;
  localparam logic [3:0] LT_POOL   = 4'd2;
  localparam logic [3:0] LT_FC     = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_KWH,
    ST_PRE_K3D,
    ST_PRE_IN,
    ST_PRE_OUT,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/al_accel_cfg_regbank.sv
// Word-addressed register bank: address decode, RW config words, CTRL pulses
// and the registered read mux.
module al_accel_cfg_regbank
  import al_accel_cfg_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_wenb,
  input  logic [31:0]       cfg_wdata,
  input  logic              cfg_renb,
  output logic [31:0]       cfg_rdata,
  output logic              cfg_rvalid,
  input  logic              busy,
  input  logic              done,
  input  logic              err,
  input  logic [31:0]       k3d,
  input  logic [15:0]       in2d,
  input  logic [15:0]       out2d,
  output logic              start_pls,
  output logic              done_clr_pls,
  output logic              irq_en,
  output logic [31:0]       i_base_addr,
  output logic [31:0]       kw_base_addr,
  output logic [31:0]       o_base_addr,
  output logic [31:0]       b_base_addr,
  output logic [31:0]       ps_base_addr,
  output logic [3:0]        cfg_layer_typ,
  output logic [3:0]        stride_width,
  output logic [3:0]        stride_height,
  output logic [15:0]       weight_kernel_patch_width,
  output logic [15:0]       weight_kernel_patch_height,
  output logic [15:0]       kernel_ifm_depth,
  output logic [15:0]       nok_ofm_depth,
  output logic [15:0]       ifm_width,
  output logic [15:0]       ifm_height,
  output logic [15:0]       ofm_width,
  output logic [15:0]       ofm_height
);

  logic [31:0] baddr;
  logic        wr_ctrl;
  logic        unused_addr_lsb;
  logic [31:0] word_q [W_IBASE:W_OFM];
  logic [31:0] word_d [W_IBASE:W_OFM];
  logic        irq_en_q, irq_en_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  assign baddr           = 32'({cfg_addr[ADDR_W-1:2], 2'b00});
  assign unused_addr_lsb = ^cfg_addr[1:0];
  assign wr_ctrl         = cfg_wenb && (baddr == OFF_CTRL);
  assign start_pls       = wr_ctrl && cfg_wdata[CTRL_START];
  assign done_clr_pls    = wr_ctrl && cfg_wdata[CTRL_DONE_CLR];

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ctrl) irq_en_d = cfg_wdata[CTRL_IRQ_EN];
    // Layer config is frozen while a run is in flight
    for (int i = W_IBASE; i <= W_OFM; i++) begin
      word_d[i] = word_q[i];
      if (cfg_wenb && !busy && (baddr == 32'(i * 4)))
        word_d[i] = (i == W_LAYER) ? {20'b0, cfg_wdata[11:0]} : cfg_wdata;
    end
    rvalid_d = cfg_renb;
    rdata_d  = rdata_q;
    if (cfg_renb) begin
      rdata_d = '0;
      case (baddr)
        OFF_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
        OFF_STATUS: begin
          rdata_d[STAT_BUSY] = busy;
          rdata_d[STAT_DONE] = done;
          rdata_d[STAT_ERR]  = err;
        end
        OFF_K3D:    rdata_d = k3d;
        OFF_SIZE2D: rdata_d = {out2d, in2d};
        default: begin
          for (int i = W_IBASE; i <= W_OFM; i++)
            if (baddr == 32'(i * 4)) rdata_d = word_q[i];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq_en_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int i = W_IBASE; i <= W_OFM; i++) word_q[i] <= '0;
    end else begin
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      for (int i = W_IBASE; i <= W_OFM; i++) word_q[i] <= word_d[i];
    end
  end

  assign cfg_rdata                  = rdata_q;
  assign cfg_rvalid                 = rvalid_q;
  assign irq_en                     = irq_en_q;
  assign i_base_addr                = word_q[W_IBASE];
  assign kw_base_addr               = word_q[W_KWBASE];
  assign o_base_addr                = word_q[W_OBASE];
  assign b_base_addr                = word_q[W_BBASE];
  assign ps_base_addr               = word_q[W_PSBASE];
  assign cfg_layer_typ              = word_q[W_LAYER][3:0];
  assign stride_width               = word_q[W_LAYER][7:4];
  assign stride_height              = word_q[W_LAYER][11:8];
  assign weight_kernel_patch_width  = word_q[W_KSIZE][15:0];
  assign weight_kernel_patch_height = word_q[W_KSIZE][31:16];
  assign kernel_ifm_depth           = word_q[W_DEPTH][15:0];
  assign nok_ofm_depth              = word_q[W_DEPTH][31:16];
  assign ifm_width                  = word_q[W_IFM][15:0];
  assign ifm_height                 = word_q[W_IFM][31:16];
  assign ofm_width                  = word_q[W_OFM][15:0];
  assign ofm_height                 = word_q[W_OFM][31:16];

endmodule

// File: rtl/al_accel_cfg_ctrl.sv
// Layer-config and run-control front end: register bank, size pre-computation
// on one shared multiplier, and the run FSM that drives the flow controller.
module al_accel_cfg_ctrl
  import al_accel_cfg_pkg::*;
#(
  parameter int ADDR_W           = 6,
  parameter bit PRECAL_SKIP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_wenb,
  input  logic [31:0]       cfg_wdata,
  input  logic              cfg_renb,
  output logic [31:0]       cfg_rdata,
  output logic              cfg_rvalid,
  output logic [31:0]       i_base_addr,
  output logic [31:0]       kw_base_addr,
  output logic [31:0]       o_base_addr,
  output logic [31:0]       b_base_addr,
  output logic [31:0]       ps_base_addr,
  output logic [3:0]        cfg_layer_typ,
  output logic [3:0]        stride_width,
  output logic [3:0]        stride_height,
  output logic [15:0]       weight_kernel_patch_width,
  output logic [15:0]       weight_kernel_patch_height,
  output logic [15:0]       kernel_ifm_depth,
  output logic [15:0]       nok_ofm_depth,
  output logic [15:0]       ifm_width,
  output logic [15:0]       ifm_height,
  output logic [15:0]       ofm_width,
  output logic [15:0]       ofm_height,
  output logic [31:0]       kernel3D_size,
  output logic [15:0]       input2D_size,
  output logic [15:0]       output2D_size,
  output logic              flow_enb,
  output logic              flow_soft_resetn,
  input  logic              flow_cal_fin,
  output logic              irq
);

  state_e      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q, irq_d;
  logic [31:0] tmp32_q, tmp32_d, k3d_q, k3d_d;
  logic [15:0] in2d_q, in2d_d, out2d_q, out2d_d;
  logic [31:0] mul_a, mul_b, mul_lo;
  logic        start_pls, done_clr_pls, irq_en;

  al_accel_cfg_regbank #(.ADDR_W(ADDR_W)) u_regbank (
    .clk                        (clk),
    .resetn                     (resetn),
    .cfg_addr                   (cfg_addr),
    .cfg_wenb                   (cfg_wenb),
    .cfg_wdata                  (cfg_wdata),
    .cfg_renb                   (cfg_renb),
    .cfg_rdata                  (cfg_rdata),
    .cfg_rvalid                 (cfg_rvalid),
    .busy                       (busy_q),
    .done                       (done_q),
    .err                        (err_q),
    .k3d                        (k3d_q),
    .in2d                       (in2d_q),
    .out2d                      (out2d_q),
    .start_pls                  (start_pls),
    .done_clr_pls               (done_clr_pls),
    .irq_en                     (irq_en),
    .i_base_addr                (i_base_addr),
    .kw_base_addr               (kw_base_addr),
    .o_base_addr                (o_base_addr),
    .b_base_addr                (b_base_addr),
    .ps_base_addr               (ps_base_addr),
    .cfg_layer_typ              (cfg_layer_typ),
    .stride_width               (stride_width),
    .stride_height              (stride_height),
    .weight_kernel_patch_width  (weight_kernel_patch_width),
    .weight_kernel_patch_height (weight_kernel_patch_height),
    .kernel_ifm_depth           (kernel_ifm_depth),
    .nok_ofm_depth              (nok_ofm_depth),
    .ifm_width                  (ifm_width),
    .ifm_height                 (ifm_height),
    .ofm_width                  (ofm_width),
    .ofm_height                 (ofm_height)
  );

  // One multiplier, operands selected by the pre-computation step; the
  // product is kept to 32 bits so every size wraps rather than saturates.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      ST_PRE_KWH: begin
        mul_a = {16'b0, weight_kernel_patch_width};
        mul_b = {16'b0, weight_kernel_patch_height};
      end
      ST_PRE_K3D: begin
        mul_a = tmp32_q;
        mul_b = {16'b0, kernel_ifm_depth};
      end
      ST_PRE_IN: begin
        mul_a = {16'b0, ifm_width};
        mul_b = {16'b0, ifm_height};
      end
      ST_PRE_OUT: begin
        mul_a = {16'b0, ofm_width};
        mul_b = {16'b0, ofm_height};
      end
      default: ;
    endcase
  end

  assign mul_lo = mul_a * mul_b;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    tmp32_d = tmp32_q;
    k3d_d   = k3d_q;
    in2d_d  = in2d_q;
    out2d_d = out2d_q;
    if (done_clr_pls) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_pls) begin
          state_d = ST_PRE_KWH;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_PRE_KWH: begin
        tmp32_d = mul_lo;
        state_d = ST_PRE_K3D;
      end
      ST_PRE_K3D: begin
        k3d_d   = mul_lo;
        state_d = ST_PRE_IN;
      end
      ST_PRE_IN: begin
        in2d_d  = mul_lo[15:0];
        state_d = ST_PRE_OUT;
      end
      ST_PRE_OUT: begin
        out2d_d = mul_lo[15:0];
        state_d = ST_RUN;
        // out2D is still being produced here, so test the fresh product
        if (PRECAL_SKIP_ZERO &&
            ((k3d_q == '0) || (in2d_q == '0) || (mul_lo[15:0] == '0))) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (flow_cal_fin) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = done_q & irq_en;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      tmp32_q <= '0;
      k3d_q   <= '0;
      in2d_q  <= '0;
      out2d_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      tmp32_q <= tmp32_d;
      k3d_q   <= k3d_d;
      in2d_q  <= in2d_d;
      out2d_q <= out2d_d;
    end
  end

  assign flow_enb         = (state_q == ST_RUN);
  assign flow_soft_resetn = !((state_q == ST_PRE_KWH) || (state_q == ST_PRE_K3D) ||
                              (state_q == ST_PRE_IN)  || (state_q == ST_PRE_OUT));
  assign irq              = irq_q;
  assign kernel3D_size    = k3d_q;
  assign input2D_size     = in2d_q;
  assign output2D_size    = out2d_q;

endmodule

// File: tb/tb_al_accel_cfg_ctrl.sv
// Directed bench for al_accel_cfg_ctrl: table of register write/readback
// vectors followed by hand-written run, error, overflow and reset sequences.
module tb_al_accel_cfg_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  cfg_addr;
  logic        cfg_wenb;
  logic [31:0] cfg_wdata;
  logic        cfg_renb;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;
  logic [31:0] i_base_addr, kw_base_addr, o_base_addr, b_base_addr, ps_base_addr;
  logic [3:0]  cfg_layer_typ, stride_width, stride_height;
  logic [15:0] weight_kernel_patch_width, weight_kernel_patch_height;
  logic [15:0] kernel_ifm_depth, nok_ofm_depth, ifm_width, ifm_height, ofm_width, ofm_height;
  logic [31:0] kernel3D_size;
  logic [15:0] input2D_size, output2D_size;
  logic        flow_enb, flow_soft_resetn, flow_cal_fin, irq;

  int n_checks = 0;
  int n_fail   = 0;

  al_accel_cfg_ctrl #(.ADDR_W(6), .PRECAL_SKIP_ZERO(1'b1)) dut (
    .clk                        (clk),
    .resetn                     (resetn),
    .cfg_addr                   (cfg_addr),
    .cfg_wenb                   (cfg_wenb),
    .cfg_wdata                  (cfg_wdata),
    .cfg_renb                   (cfg_renb),
    .cfg_rdata                  (cfg_rdata),
    .cfg_rvalid                 (cfg_rvalid),
    .i_base_addr                (i_base_addr),
    .kw_base_addr               (kw_base_addr),
    .o_base_addr                (o_base_addr),
    .b_base_addr                (b_base_addr),
    .ps_base_addr               (ps_base_addr),
    .cfg_layer_typ              (cfg_layer_typ),
    .stride_width               (stride_width),
    .stride_height              (stride_height),
    .weight_kernel_patch_width  (weight_kernel_patch_width),
    .weight_kernel_patch_height (weight_kernel_patch_height),
    .kernel_ifm_depth           (kernel_ifm_depth),
    .nok_ofm_depth              (nok_ofm_depth),
    .ifm_width                  (ifm_width),
    .ifm_height                 (ifm_height),
    .ofm_width                  (ofm_width),
    .ofm_height                 (ofm_height),
    .kernel3D_size              (kernel3D_size),
    .input2D_size               (input2D_size),
    .output2D_size              (output2D_size),
    .flow_enb                   (flow_enb),
    .flow_soft_resetn           (flow_soft_resetn),
    .flow_cal_fin               (flow_cal_fin),
    .irq                        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wenb  = 1'b1;
    cyc();
    cfg_wenb  = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    cfg_addr = a;
    cfg_renb = 1'b1;
    cyc();
    cfg_renb = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic wait_enb(input int maxc);
    int n = 0;
    while (!flow_enb && n < maxc) begin
      cyc();
      n++;
    end
    check("enb_wait", {31'b0, flow_enb}, 32'd1);
  endtask

  task automatic finish_run();
    flow_cal_fin = 1'b1;
    cyc();
    flow_cal_fin = 1'b0;
  endtask

  task automatic program_std();
    wr(6'h20, 32'h0003_0003);
    wr(6'h24, 32'h0008_0010);
    wr(6'h28, 32'h0020_0020);
    wr(6'h2C, 32'h001E_001E);
  endtask

  task automatic check_start_latency(input string tag);
    for (int i = 1; i <= 4; i++) begin
      check({tag, "_soft_low"}, {31'b0, flow_soft_resetn}, 32'd0);
      check({tag, "_enb_low"},  {31'b0, flow_enb},         32'd0);
      cyc();
    end
    check({tag, "_enb_rise"},  {31'b0, flow_enb},         32'd1);
    check({tag, "_soft_high"}, {31'b0, flow_soft_resetn}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int          cnt;

    vecs[0] = '{"ibase",   6'h08, 1'b1, 32'h1000_0000, 32'h1000_0000};
    vecs[1] = '{"kwbase",  6'h0C, 1'b1, 32'h2000_0004, 32'h2000_0004};
    vecs[2] = '{"obase",   6'h10, 1'b1, 32'h3000_0008, 32'h3000_0008};
    vecs[3] = '{"bbase",   6'h14, 1'b1, 32'h4000_000C, 32'h4000_000C};
    vecs[4] = '{"psbase",  6'h18, 1'b1, 32'h5000_0010, 32'h5000_0010};
    vecs[5] = '{"layer",   6'h1C, 1'b1, 32'hFFFF_F321, 32'h0000_0321};
    vecs[6] = '{"unmap_w", 6'h38, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[7] = '{"unmap_r", 6'h3C, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{"status0", 6'h04, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{"k3d0",    6'h30, 1'b0, 32'h0000_0000, 32'h0000_0000};

    resetn = 1'b0; cfg_addr = '0; cfg_wenb = 1'b0; cfg_wdata = '0;
    cfg_renb = 1'b0; flow_cal_fin = 1'b0;
    repeat (3) cyc();
    check("rst_enb",    {31'b0, flow_enb},         32'd0);
    check("rst_soft",   {31'b0, flow_soft_resetn}, 32'd1);
    check("rst_irq",    {31'b0, irq},              32'd0);
    check("rst_rvalid", {31'b0, cfg_rvalid},       32'd0);
    check("rst_rdata",  cfg_rdata,                 32'd0);
    check("rst_k3d",    kernel3D_size,             32'd0);
    check("rst_ibase",  i_base_addr,               32'd0);
    resetn = 1'b1;
    cyc();

    for (int i = 0; i <= 9; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      check(vecs[i].name, d, vecs[i].exp);
      check({vecs[i].name, "_rvalid"}, {31'b0, cfg_rvalid}, 32'd1);
    end
    cyc();
    check("rvalid_pulse", {31'b0, cfg_rvalid}, 32'd0);
    check("ps_port",  ps_base_addr, 32'h5000_0010);
    check("typ_port", {28'b0, cfg_layer_typ}, 32'd1);
    check("sw_port",  {28'b0, stride_width},  32'd2);
    check("sh_port",  {28'b0, stride_height}, 32'd3);

    // read and write to the same word in one cycle: old value returned
    cfg_addr = 6'h08; cfg_wdata = 32'hAAAA_5555; cfg_wenb = 1'b1; cfg_renb = 1'b1;
    cyc();
    cfg_wenb = 1'b0; cfg_renb = 1'b0;
    check("rw_same_old", cfg_rdata, 32'h1000_0000);
    rd(6'h08, d);
    check("rw_same_new", d, 32'hAAAA_5555);

    // main run: 3x3x16 kernel, 32x32 in, 30x30 out, irq enabled
    program_std();
    wr(6'h00, 32'h3);
    check_start_latency("run1");
    check("k3d_144",   kernel3D_size,          32'd144);
    check("in2d_1024", {16'b0, input2D_size},  32'd1024);
    check("out2d_900", {16'b0, output2D_size}, 32'd900);
    rd(6'h34, d);
    check("size2d_rd", d, {16'd900, 16'd1024});
    rd(6'h04, d);
    check("status_busy", d, 32'h1);
    wr(6'h28, 32'hFFFF_0000);
    wr(6'h00, 32'h3);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (!flow_enb || !flow_soft_resetn) cnt++;
      cyc();
    end
    check("enb_held", cnt, 32'd0);
    rd(6'h28, d);
    check("ifm_locked", d, 32'h0020_0020);
    finish_run();
    check("enb_fall", {31'b0, flow_enb}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (flow_enb) cnt++;
      cyc();
    end
    check("single_run", cnt, 32'd0);
    rd(6'h04, d);
    check("status_done", d, 32'h2);
    check("irq_set", {31'b0, irq}, 32'd1);
    wr(6'h00, 32'h6);
    cyc();
    check("irq_clr", {31'b0, irq}, 32'd0);
    rd(6'h04, d);
    check("status_clr", d, 32'h0);

    // zero output size aborts the run
    wr(6'h2C, 32'h001E_0000);
    wr(6'h00, 32'h1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (flow_enb) cnt++;
      cyc();
    end
    check("err_no_enb", cnt, 32'd0);
    rd(6'h04, d);
    check("status_err", d, 32'h6);
    check("err_irq_off", {31'b0, irq}, 32'd0);
    wr(6'h00, 32'h4);
    rd(6'h04, d);
    check("status_err_clr", d, 32'h0);

    // truncating products
    wr(6'h20, 32'hFFFF_FFFF);
    wr(6'h24, 32'h0008_FFFF);
    wr(6'h28, 32'h012C_012C);
    wr(6'h2C, 32'h001E_001E);
    wr(6'h00, 32'h1);
    wait_enb(20);
    check("k3d_ovf",  kernel3D_size,          32'h0002_FFFF);
    check("in2d_ovf", {16'b0, input2D_size},  32'd24464);
    check("out2d_ok", {16'b0, output2D_size}, 32'd900);
    finish_run();
    wr(6'h00, 32'h4);

    // reset in the middle of a run
    program_std();
    wr(6'h00, 32'h3);
    wait_enb(20);
    repeat (3) cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    check("mrst_enb",   {31'b0, flow_enb},         32'd0);
    check("mrst_soft",  {31'b0, flow_soft_resetn}, 32'd1);
    check("mrst_irq",   {31'b0, irq},              32'd0);
    check("mrst_k3d",   kernel3D_size,             32'd0);
    check("mrst_in2d",  {16'b0, input2D_size},     32'd0);
    check("mrst_kw",    {16'b0, weight_kernel_patch_width}, 32'd0);
    check("mrst_ibase", i_base_addr,               32'd0);
    flow_cal_fin = 1'b1;
    repeat (3) cyc();
    flow_cal_fin = 1'b0;
    check("mrst_fin_enb", {31'b0, flow_enb}, 32'd0);
    rd(6'h04, d);
    check("mrst_status", d, 32'h0);
    program_std();
    wr(6'h00, 32'h1);
    check_start_latency("run2");
    check("run2_k3d", kernel3D_size, 32'd144);
    finish_run();
    rd(6'h04, d);
    check("run2_done", d, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
